ckey_debounce: RTL
==================

CKEY_DEBOUNCE -- requirements
Module: ckey_debounce

Interface
REQ-001 SHALL have parameter DEB_CNT, default 500000, meaning stable-cycle count before an accepted change (10 ms at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter RST_VAL, default 4'b1111, meaning the 4-bit value loaded on reset into the synchronizers and ckey_out (all switches off).
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset; it is synchronous and active-high.
REQ-005 SHALL have port ckey_in  input  [4:1]  meaning raw asynchronous DIP-switch levels; on = 0, off = 1.
REQ-006 SHALL have port ckey_out  output  [4:1]  meaning debounced registered switch levels that drive the downstream LED stage directly.
REQ-007 SHALL have port ckey_chg  output  [4:1]  meaning a one-cycle pulse per bit when the matching ckey_out bit changes.

Function
REQ-008 SHALL pass each ckey_in bit through a 2-flop synchronizer (sync1, then sync2) before any other use.
REQ-009 SHALL keep one independent counter per bit, width clog2(DEB_CNT); bits never interact.
REQ-010 SHALL, per bit, in any cycle where sync2 != ckey_out and cnt < DEB_CNT-1, increment cnt by 1.
REQ-011 SHALL, per bit, in any cycle where sync2 != ckey_out and cnt == DEB_CNT-1, load ckey_out <= sync2 and set cnt <= 0 on that edge.
REQ-012 SHALL, per bit, in any cycle where sync2 == ckey_out, set cnt <= 0, so that any mismatch shorter than DEB_CNT cycles is discarded.
REQ-013 SHALL update ckey_out exactly DEB_CNT+1 rising edges after the edge that first samples a new steady level into sync1; that sampling edge is E0 and the update happens at E(DEB_CNT+1).
REQ-014 SHALL never let the counter wrap; it is bounded by REQ-011 and REQ-012.
REQ-015 SHALL, when the feature in REQ-021 is compiled in, assert ckey_chg[i] for exactly one cycle, registered on the same edge that updates ckey_out[i].
REQ-016 SHALL, when several bits qualify on the same edge, update and pulse each of them on that edge.
REQ-017 SHALL have no combinational path from ckey_in to either output.

Reset
REQ-018 SHALL, on any edge with rst = 1, load sync1 = sync2 = ckey_out = RST_VAL, all cnt = 0 and ckey_chg = 0.
REQ-019 SHALL, when reset is asserted mid-count, abandon any pending change; no ckey_chg pulse is generated by reset itself.
REQ-020 SHALL give reset priority over every other update.

Configuration
REQ-021 SHALL, when macro CKEY_DEBOUNCE_CHG_EN is defined, implement the ckey_chg pulse registers described in REQ-015.
REQ-022 SHALL, when CKEY_DEBOUNCE_CHG_EN is undefined, keep the ckey_chg port and drive it constant 4'b0000 with no registers; ckey_out behaviour is identical in both builds.

Verification (bench uses DEB_CNT=4, RST_VAL=4'b1111)
REQ-023 SHALL cover: hold rst for 2 cycles with ckey_in = 4'b0000 -> ckey_out = 4'b1111 and ckey_chg = 0 throughout reset and the first cycle after it.
REQ-024 SHALL cover: ckey_in[1] 1 -> 0 steady, sampled at E0 -> ckey_out = 4'b1110 first seen after E5; ckey_chg = 4'b0001 for one cycle only, and 0 when the macro is undefined.
REQ-025 SHALL cover: ckey_in[2] pulses low for 3 cycles, then returns high -> ckey_out stays 4'b1111 and ckey_chg stays 0.
REQ-026 SHALL cover: ckey_in goes 4'b1111 -> 4'b0000 in one cycle -> all four bits update on the same edge, with ckey_chg = 4'b1111 for one cycle.
REQ-027 SHALL cover: ckey_in[3] low for 3 cycles, then rst pulses for 1 cycle, then low continues -> no update before E(DEB_CNT+1) measured from the first post-reset sampling edge; counting restarts from 0.
REQ-028 SHALL cover: ckey_in[4] alternates every 2 cycles for 40 cycles, then settles at 0 -> ckey_out[4] changes once, 5 edges after it settles.

Source files
------------

// File: rtl/ckey_debounce.sv
// Four-switch DIP debouncer: 2-flop synchronizer plus saturating stable-count per bit.
// Optional one-cycle change pulses on ckey_chg when CKEY_DEBOUNCE_CHG_EN is defined.

module ckey_debounce_lane #(
    parameter int   DEB_CNT = 500000,
    parameter logic RST_BIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic chg
);
    localparam int CW = ($clog2(DEB_CNT) < 1) ? 1 : $clog2(DEB_CNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          fire;

    // Mismatch has now persisted for DEB_CNT consecutive compares.
    assign fire = (sync2 != dout) && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RST_BIT;
            sync2 <= RST_BIT;
            dout  <= RST_BIT;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (fire) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef CKEY_DEBOUNCE_CHG_EN
    always_ff @(posedge clk) begin
        if (rst) chg <= 1'b0;
        else     chg <= fire;
    end
`else
    assign chg = 1'b0;
`endif

endmodule

module ckey_debounce #(
    parameter int         DEB_CNT = 500000,
    parameter logic [4:1] RST_VAL = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:1] ckey_in,
    output logic [4:1] ckey_out,
    output logic [4:1] ckey_chg
);
    for (genvar i = 1; i <= 4; i++) begin : g_lane
        ckey_debounce_lane #(
            .DEB_CNT (DEB_CNT),
            .RST_BIT (RST_VAL[i])
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .din  (ckey_in[i]),
            .dout (ckey_out[i]),
            .chg  (ckey_chg[i])
        );
    end

endmodule
